// File: rtl/accel_loader_pkg.sv
`default_nettype none
// ============================================================================
// accel_loader_pkg : loader state encoding, error codes, default job sizes
// Revision: 1.0
// ============================================================================
package accel_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_IMG = 3'd1,
        ST_LOAD_W   = 3'd2,
        ST_RUN      = 3'd3,
        ST_FINISH   = 3'd4,
        ST_ABORT    = 3'd5
    } state_e;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE    = 2'd0;
    localparam err_t ERR_SHORT   = 2'd1;
    localparam err_t ERR_LONG    = 2'd2;
    localparam err_t ERR_TIMEOUT = 2'd3;

    // Job sizes also used by the accelerator's memory block
    localparam int DEF_IMG_BYTES = 1024;
    localparam int DEF_WGT_BYTES = 25;
    localparam int DEF_TIMEOUT   = 65535;

    localparam int CNT_W = 11;
    localparam int TMR_W = 16;

endpackage
`default_nettype wire

// File: rtl/byte_strobe_reg.sv
`default_nettype none
// ============================================================================
// byte_strobe_reg : registers an accepted byte and emits a one-cycle strobe
// Revision: 1.0
// ============================================================================
module byte_strobe_reg
    import accel_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load_r_req,
    input  logic       i_load_w_req,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_load_r,
    output logic       o_load_wr
);

    logic [7:0] data_d, data_q;
    logic       load_r_d, load_r_q;
    logic       load_wr_d, load_wr_q;

    // Data holds between strobes so gaps leave the last byte on the bus
    always_comb begin
        data_d    = data_q;
        load_r_d  = i_load_r_req;
        load_wr_d = i_load_w_req;
        if (i_load_r_req || i_load_w_req) begin
            data_d = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= 8'd0;
            load_r_q  <= 1'b0;
            load_wr_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            load_r_q  <= load_r_d;
            load_wr_q <= load_wr_d;
        end
    end

    assign o_data    = data_q;
    assign o_load_r  = load_r_q;
    assign o_load_wr = load_wr_q;

endmodule
`default_nettype wire

// File: rtl/accel_loader.sv
`default_nettype none
// ============================================================================
// accel_loader : sequences a host byte packet into the accelerator load port
// Revision: 1.0
// ============================================================================
module accel_loader
    import accel_loader_pkg::*;
#(
    parameter int IMG_BYTES = DEF_IMG_BYTES,
    parameter int WGT_BYTES = DEF_WGT_BYTES,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       relu_en,
    input  logic       sel_in,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic [7:0] acc_data,
    output logic       acc_load_r,
    output logic       acc_load_wr,
    output logic       acc_relu,
    output logic       acc_sel,
    input  logic       acc_done,
    output logic       busy,
    output logic       job_done,
    output logic [1:0] err
);

    localparam logic [CNT_W-1:0] c_img_last = CNT_W'(IMG_BYTES - 1);
    localparam logic [CNT_W-1:0] c_wgt_last = CNT_W'(WGT_BYTES - 1);
    localparam logic [TMR_W-1:0] c_tmo_last = TMR_W'(TIMEOUT - 1);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [TMR_W-1:0] timer_d, timer_q;
    err_t             err_d, err_q;
    logic             relu_d, relu_q;
    logic             sel_d, sel_q;
    logic             s_ready_d, s_ready_q;
    logic             job_done_d, job_done_q;
    logic             hs, fwd_r, fwd_w;

    assign hs = s_valid && s_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        err_d      = err_q;
        relu_d     = relu_q;
        sel_d      = sel_q;
        job_done_d = 1'b0;
        fwd_r      = 1'b0;
        fwd_w      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_IMG;
                    relu_d  = relu_en;
                    sel_d   = sel_in;
                    cnt_d   = '0;
                    err_d   = ERR_NONE;
                end
            end
            ST_LOAD_IMG: begin
                if (hs) begin
                    fwd_r = 1'b1;
                    if (s_last) begin
                        err_d   = ERR_SHORT;
                        state_d = ST_ABORT;
                    end else if (cnt_q == c_img_last) begin
                        state_d = ST_LOAD_W;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            ST_LOAD_W: begin
                if (hs) begin
                    fwd_w = 1'b1;
                    // The final kernel byte decides between run and long-packet abort
                    if (cnt_q == c_wgt_last) begin
                        cnt_d = '0;
                        if (s_last) begin
                            state_d = ST_RUN;
                            timer_d = '0;
                        end else begin
                            err_d   = ERR_LONG;
                            state_d = ST_ABORT;
                        end
                    end else if (s_last) begin
                        err_d   = ERR_SHORT;
                        state_d = ST_ABORT;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            ST_RUN: begin
                if (acc_done) begin
                    state_d    = ST_FINISH;
                    job_done_d = 1'b1;
                end else if (timer_q == c_tmo_last) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ABORT;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_ABORT: begin
                // Only a long packet has trailing bytes left to swallow
                if (err_q != ERR_LONG) begin
                    state_d = ST_IDLE;
                end else if (hs && s_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        s_ready_d = (state_d == ST_LOAD_IMG) || (state_d == ST_LOAD_W) ||
                    (state_d == ST_ABORT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            timer_q    <= '0;
            err_q      <= ERR_NONE;
            relu_q     <= 1'b0;
            sel_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            job_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            relu_q     <= relu_d;
            sel_q      <= sel_d;
            s_ready_q  <= s_ready_d;
            job_done_q <= job_done_d;
        end
    end

    byte_strobe_reg u_strobe (
        .clk          (clk),
        .rst          (reset),
        .i_load_r_req (fwd_r),
        .i_load_w_req (fwd_w),
        .i_data       (s_data),
        .o_data       (acc_data),
        .o_load_r     (acc_load_r),
        .o_load_wr    (acc_load_wr)
    );

    assign s_ready  = s_ready_q;
    assign acc_relu = relu_q;
    assign acc_sel  = sel_q;
    assign busy     = (state_q != ST_IDLE);
    assign job_done = job_done_q;
    assign err      = err_q;

endmodule
`default_nettype wire
